// File: rtl/reorder_buffer_if.sv
// Issue / CDB / query / regfile-write bundle between the pipeline and reorder_buffer.
interface reorder_buffer_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3
);
  logic             flush;
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic [TAG_W-1:0] qry_tag;
  logic             qry_ready;
  logic [31:0]      qry_data;
  logic             ROBwriteEnable;
  logic [4:0]       ROBwriteIndex;
  logic [31:0]      ROBwriteData;
  logic [TAG_W:0]   count;

  modport master (
    output flush, alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, qry_tag,
    input  alloc_ready, alloc_tag, qry_ready, qry_data,
           ROBwriteEnable, ROBwriteIndex, ROBwriteData, count
  );

  modport slave (
    input  flush, alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, qry_tag,
    output alloc_ready, alloc_tag, qry_ready, qry_data,
           ROBwriteEnable, ROBwriteIndex, ROBwriteData, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue feeding regfile with pulsed writes (pulse, then two low cycles).
// Optional ROB_CDB_BYPASS_EN: forward a same-cycle CDB broadcast to the query port.
module reorder_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3
) (
  input logic            clk,
  input logic            rst,
  reorder_buffer_if.slave bus
);
  localparam int unsigned CNT_W = TAG_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             we_q, we_d;
  logic [4:0]       widx_q, widx_d;
  logic [31:0]      wdata_q, wdata_d;

  logic alloc_ready, alloc_fire, retire;

  assign alloc_ready = (count_q != CNT_W'(DEPTH));
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign retire      = (state_q == IDLE) && valid_q[head_q] && ready_q[head_q];

  assign bus.alloc_ready    = alloc_ready;
  assign bus.alloc_tag      = tail_q;
  assign bus.count          = count_q;
  assign bus.ROBwriteEnable = we_q;
  assign bus.ROBwriteIndex  = widx_q;
  assign bus.ROBwriteData   = wdata_q;

  // Operand lookup.
  always_comb begin
    bus.qry_ready = valid_q[bus.qry_tag] && ready_q[bus.qry_tag];
    bus.qry_data  = data_q[bus.qry_tag];
`ifdef ROB_CDB_BYPASS_EN
    if (bus.cdb_valid && (bus.cdb_tag == bus.qry_tag) && valid_q[bus.qry_tag]) begin
      bus.qry_ready = 1'b1;
      bus.qry_data  = bus.cdb_data;
    end
`endif
  end

  // Next state: allocate, CDB deposit, commit FSM; flush overrides all of it.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ready_d = ready_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we_d    = 1'b0;
    widx_d  = widx_q;
    wdata_d = wdata_q;

    if (bus.flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = IDLE;
    end else begin
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = bus.alloc_rd;
        tail_d          = TAG_W'(tail_q + TAG_W'(1));
      end
      if (bus.cdb_valid && valid_q[bus.cdb_tag] && !ready_q[bus.cdb_tag]) begin
        ready_d[bus.cdb_tag] = 1'b1;
        data_d[bus.cdb_tag]  = bus.cdb_data;
      end
      unique case (state_q)
        IDLE: begin
          if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = TAG_W'(head_q + TAG_W'(1));
            if (rd_q[head_q] != 5'd0) begin
              we_d    = 1'b1;
              widx_d  = rd_q[head_q];
              wdata_d = data_q[head_q];
              state_d = WRITE;
            end
          end
        end
        WRITE:   state_d = GAP;
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
      count_d = CNT_W'(count_q + CNT_W'(alloc_fire) - CNT_W'(retire));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
    end
  end

  // Payload storage is qualified by valid/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commit ordering, pulse spacing, full/wrap, flush, query.
module tb_reorder_buffer;
`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc, last, np;
  bit   seen_we;

  reorder_buffer_if #(.DEPTH(8), .TAG_W(3)) rob_if ();

  reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rob_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rob_if.flush       = 1'b0;
    rob_if.alloc_valid = 1'b0;
    rob_if.alloc_rd    = 5'd0;
    rob_if.cdb_valid   = 1'b0;
    rob_if.cdb_tag     = 3'd0;
    rob_if.cdb_data    = 32'd0;
    rob_if.qry_tag     = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    rob_if.alloc_valid = 1'b1;
    rob_if.alloc_rd    = rd;
    step();
    rob_if.alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
    rob_if.cdb_valid = 1'b1;
    rob_if.cdb_tag   = tag;
    rob_if.cdb_data  = data;
  endtask

  // Step and track pulses: index must be 1,2,3 in order, rising edges 3 cycles apart.
  task automatic tick_mon();
    step();
    cyc++;
    if (rob_if.ROBwriteEnable) begin
      check("t2_order", 64'(rob_if.ROBwriteIndex), 64'(np + 1));
      if (np > 0) check("t2_spacing", 64'(cyc - last), 64'd3);
      last = cyc;
      np++;
    end
  endtask

  initial begin
    idle_inputs();
    do_reset();
    rst = 1'b1;
    #1;
    check("rst_we",    64'(rob_if.ROBwriteEnable), 64'd0);
    check("rst_idx",   64'(rob_if.ROBwriteIndex),  64'd0);
    check("rst_data",  64'(rob_if.ROBwriteData),   64'd0);
    check("rst_ready", 64'(rob_if.alloc_ready),    64'd1);
    check("rst_tag",   64'(rob_if.alloc_tag),      64'd0);
    check("rst_qry",   64'(rob_if.qry_ready),      64'd0);
    check("rst_count", 64'(rob_if.count),          64'd0);
    step();
    rst = 1'b0;

    // Single register-writing retire.
    alloc(5'd5);
    check("t1_count1", 64'(rob_if.count),     64'd1);
    check("t1_tag1",   64'(rob_if.alloc_tag), 64'd1);
    cdb(3'd0, 32'h1234);
    step();
    rob_if.cdb_valid = 1'b0;
    check("t1_we_early", 64'(rob_if.ROBwriteEnable), 64'd0);
    step();
    check("t1_we",    64'(rob_if.ROBwriteEnable), 64'd1);
    check("t1_idx",   64'(rob_if.ROBwriteIndex),  64'd5);
    check("t1_data",  64'(rob_if.ROBwriteData),   64'h1234);
    check("t1_count", 64'(rob_if.count),          64'd0);
    step();
    check("t1_low1", 64'(rob_if.ROBwriteEnable), 64'd0);
    step();
    check("t1_low2", 64'(rob_if.ROBwriteEnable), 64'd0);
    check("t1_hold", 64'(rob_if.ROBwriteIndex),  64'd5);

    // Out-of-order results, in-order retirement.
    do_reset();
    alloc(5'd1);
    alloc(5'd2);
    alloc(5'd3);
    cyc = 0; last = 0; np = 0;
    cdb(3'd2, 32'h33);
    tick_mon();
    cdb(3'd0, 32'h11);
    tick_mon();
    cdb(3'd1, 32'h22);
    tick_mon();
    rob_if.cdb_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick_mon();
    check("t2_npulses", 64'(np),           64'd3);
    check("t2_count",   64'(rob_if.count), 64'd0);

    // Full queue, ignored 9th allocation, wrap of tail.
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1));
    rob_if.alloc_valid = 1'b1;
    rob_if.alloc_rd    = 5'd9;
    check("t3_full_ready", 64'(rob_if.alloc_ready), 64'd0);
    check("t3_full_count", 64'(rob_if.count),       64'd8);
    check("t3_wrap_tag",   64'(rob_if.alloc_tag),   64'd0);
    step();
    check("t3_ignored", 64'(rob_if.count), 64'd8);
    cdb(3'd0, 32'h55);
    step();
    rob_if.cdb_valid = 1'b0;
    step();
    check("t3_commit_we",  64'(rob_if.ROBwriteEnable), 64'd1);
    check("t3_commit_idx", 64'(rob_if.ROBwriteIndex),  64'd1);
    check("t3_cnt7",       64'(rob_if.count),          64'd7);
    check("t3_reopen",     64'(rob_if.alloc_ready),    64'd1);
    check("t3_reuse_tag",  64'(rob_if.alloc_tag),      64'd0);
    step();
    rob_if.alloc_valid = 1'b0;
    check("t3_refill", 64'(rob_if.count),     64'd8);
    check("t3_tail1",  64'(rob_if.alloc_tag), 64'd1);
    rob_if.qry_tag = 3'd0;
    #1;
    check("t3_qry_new", 64'(rob_if.qry_ready), 64'd0);

    // rd=0 retires silently.
    do_reset();
    alloc(5'd0);
    cdb(3'd0, 32'hFF);
    step();
    rob_if.cdb_valid = 1'b0;
    check("t4_cnt1", 64'(rob_if.count), 64'd1);
    seen_we = 1'b0;
    step();
    check("t4_cnt0", 64'(rob_if.count), 64'd0);
    seen_we = rob_if.ROBwriteEnable;
    for (int i = 0; i < 4; i++) begin
      step();
      seen_we = seen_we | rob_if.ROBwriteEnable;
    end
    check("t4_no_pulse", 64'(seen_we), 64'd0);

    // Flush beats a same-cycle broadcast.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1));
    check("t5_cnt4", 64'(rob_if.count), 64'd4);
    rob_if.flush = 1'b1;
    cdb(3'd0, 32'h77);
    step();
    rob_if.flush     = 1'b0;
    rob_if.cdb_valid = 1'b0;
    check("t5_count", 64'(rob_if.count),     64'd0);
    check("t5_tag",   64'(rob_if.alloc_tag), 64'd0);
    rob_if.qry_tag = 3'd0;
    #1;
    check("t5_qry", 64'(rob_if.qry_ready), 64'd0);
    seen_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      seen_we = seen_we | rob_if.ROBwriteEnable;
    end
    check("t5_no_pulse", 64'(seen_we), 64'd0);

    // Query during broadcast.
    do_reset();
    alloc(5'd7);
    rob_if.qry_tag = 3'd0;
    cdb(3'd0, 32'hABCD);
    #1;
    check("t6_same_cycle", {31'd0, rob_if.qry_ready, rob_if.qry_ready ? rob_if.qry_data : 32'd0},
          BYP ? {31'd0, 1'b1, 32'hABCD} : 64'd0);
    step();
    rob_if.cdb_valid = 1'b0;
    #1;
    check("t6_next_ready", 64'(rob_if.qry_ready), 64'd1);
    check("t6_next_data",  64'(rob_if.qry_data),  64'hABCD);
    step();
    check("t6_retired_qry", 64'(rob_if.qry_ready),      64'd0);
    check("t6_we",          64'(rob_if.ROBwriteEnable), 64'd1);
    check("t6_idx",         64'(rob_if.ROBwriteIndex),  64'd7);

    // Asynchronous reset kills a pulse mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    check("t7_async_rst", 64'(rob_if.ROBwriteEnable), 64'd0);
    step();
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue between the execution units and `regfile`.
- Issue allocates one entry per instruction, tagged with its destination register.
- The common data bus (CDB) deposits results into entries by tag.
- The head entry retires in program order through the `ROBwriteEnable` / `ROBwriteIndex` / `ROBwriteData` port of `regfile`.
- `regfile` samples on the rising edge of `ROBwriteEnable`, so every write is a one-cycle pulse followed by a mandatory low cycle.

## Interface

Parameters:
- `DEPTH`, 8, number of entries; must be a power of two.
- `TAG_W`, 3, tag width; equals log2(`DEPTH`).

Ports:
- `clk`  input  1  the single clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `flush`  input  1  synchronous squash of all entries.
- `alloc_valid`  input  1  issue requests an entry.
- `alloc_rd`  input  5  destination register of the issuing instruction.
- `alloc_ready`  output  1  entry available (count < `DEPTH`).
- `alloc_tag`  output  `TAG_W`  tag to be assigned; equals the tail pointer.
- `cdb_valid`  input  1  result broadcast valid.
- `cdb_tag`  input  `TAG_W`  tag of the broadcast result.
- `cdb_data`  input  32  broadcast result value.
- `qry_tag`  input  `TAG_W`  operand lookup tag.
- `qry_ready`  output  1  queried entry is valid and has its result.
- `qry_data`  output  32  queried entry's result.
- `ROBwriteEnable`  output  1  registered write pulse to `regfile`.
- `ROBwriteIndex`  output  5  register index for the write.
- `ROBwriteData`  output  32  data for the write.
- `count`  output  `TAG_W`+1  number of occupied entries.

## Operation

Storage and pointers:
- Each entry holds `valid`, `ready`, `rd[4:0]` and `data[31:0]`.
- `head` and `tail` pointers are `TAG_W` bits wide and wrap modulo `DEPTH`.

Allocate:
- Occurs when `alloc_valid && alloc_ready`.
- Sets entry[`tail`] to valid=1, ready=0, rd=`alloc_rd`.
- Then `tail`+1 and `count`+1.

CDB write:
- Occurs when `cdb_valid` is high, entry[`cdb_tag`] is valid and not yet ready.
- Stores `cdb_data` and sets ready=1.
- A broadcast to an invalid or already-ready entry is ignored.

Commit FSM, states IDLE, WRITE, GAP:
- IDLE, head entry valid and ready, rd≠0: register `ROBwriteIndex`=rd, `ROBwriteData`=data and `ROBwriteEnable`=1; clear the head entry's valid bit; `head`+1; go to WRITE.
- IDLE, head entry valid and ready, rd=0: retire silently (clear valid, `head`+1, no pulse); stay in IDLE. At most one retire per cycle.
- WRITE: `ROBwriteEnable`=0; go to GAP.
- GAP: go to IDLE. This guarantees a low cycle before the next rising edge.

Count under simultaneous events:
- Allocate and retire in the same cycle leave `count` unchanged.
- `alloc_ready` is derived from the registered `count`. When full, a same-cycle retire does not open a slot until the next cycle.

Query:
- `qry_ready`/`qry_data` are combinational reads of entry[`qry_tag`].
- `qry_ready` is 0 for an invalid entry.

Flush:
- Priority over allocate, CDB write and commit in the same cycle.
- Clears all valid bits; `head`=`tail`=`count`=0; FSM returns to IDLE; `ROBwriteEnable`=0 the following cycle.
- A pulse already registered before the flush edge is a completed retire.

## Timing

Reset values (while `rst` is high):
- `head`=`tail`=`count`=0, all valid=0, FSM IDLE.
- `ROBwriteEnable`=0, `ROBwriteIndex`=0, `ROBwriteData`=0.
- `alloc_ready`=1, `alloc_tag`=0, `qry_ready`=0.

Between pulses, `ROBwriteIndex`/`ROBwriteData` hold their last value.

Latencies:
- CDB write at edge N; head commit decision uses the registered ready bit, so `ROBwriteEnable` is high in cycle N+1 at the earliest.
- Register-writing commit throughput is 1 per 3 cycles: WRITE, GAP, then IDLE evaluates the next head.
- `regfile` sees the write at the rising edge of the pulse, i.e. edge N+1 plus clock-to-q.

Assertion of `rst` mid-pulse forces `ROBwriteEnable` low immediately (asynchronous).

## Configuration

- `ROB_CDB_BYPASS_EN` defined: when `cdb_valid` is high and `cdb_tag`==`qry_tag` for a valid entry, the query returns `qry_ready`=1 and `qry_data`=`cdb_data` in the same cycle.
- Not defined: query results reflect only registered entry state, so a broadcast becomes visible one cycle later.
- Commit behaviour is identical in both builds.

## Test plan

- Reset, then allocate rd=5 (tag 0), CDB tag 0 data 0x1234 -> next cycle `ROBwriteEnable`=1, `ROBwriteIndex`=5, `ROBwriteData`=0x1234, then low for two cycles; `count` back to 0.
- Allocate rd=1,2,3; CDB results in order 3,1,2 (tags 2,0,1) -> three pulses strictly in order rd=1,2,3, each separated by exactly two low cycles.
- Allocate 8 entries -> `alloc_ready`=0, `count`=8; a 9th `alloc_valid` is ignored; `tail` wraps to 0; after one commit, `alloc_ready`=1 and the next allocation receives tag 0.
- Allocate rd=0 with CDB data 0xFF -> entry retires, `ROBwriteEnable` never rises, `count` decrements by 1.
- Flush with 4 entries pending and a CDB broadcast in the same cycle -> `count`=0, no pulse afterwards, next `alloc_tag`=0.
- Query a tag while the CDB broadcasts it with 0xABCD -> `qry_ready`=1, `qry_data`=0xABCD in the same cycle with `ROB_CDB_BYPASS_EN`; one cycle later without it.
